zeroriscy_irq_ctrl_multi: RTL and testbench
===========================================

ZERORISCY_IRQ_CTRL_MULTI -- requirements
Module: zeroriscy_irq_ctrl_multi

Interface
REQ-001 Parameter NUM_IRQ, default 32, number of interrupt sources, legal range 1..32.
REQ-002 Parameter EDGE_MASK, width NUM_IRQ, default all zeros, bit i = 1 makes source i edge-triggered; bit i = 0 makes it level-triggered.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 irq_i  input  NUM_IRQ  interrupt lines, bit i = source i.
REQ-006 irq_en_i  input  NUM_IRQ  per-source enable mask.
REQ-007 m_IE_i  input  1  global machine-mode interrupt enable from CSR.
REQ-008 ctrl_ack_i  input  1  controller accepted the presented interrupt.
REQ-009 ctrl_kill_i  input  1  controller withdrew the presented interrupt, e.g. on a flush.
REQ-010 irq_req_ctrl_o  output  1  interrupt request to the controller.
REQ-011 irq_id_ctrl_o  output  5  ID of the requested interrupt, zero-extended from the source index.
REQ-012 irq_pending_o  output  NUM_IRQ  pending vector, before the per-source enable mask is applied.

Function
REQ-013 Edge sources shall register irq_i into irq_q each cycle; rising edge of source i = irq_i[i] & ~irq_q[i].
REQ-014 An edge source's pending bit shall be set on the clock edge following a detected rising edge, and shall stay set until cleared per REQ-021.
REQ-015 A level source's pending bit shall equal irq_i[i] combinationally; it is never latched.
REQ-016 eligible = pending & irq_en_i; the selected source shall be the lowest-index eligible bit (fixed priority, index 0 highest).
REQ-017 FSM states shall be IDLE, IRQ_PENDING and IRQ_DONE; irq_req_ctrl_o = (state == IRQ_PENDING).
REQ-018 IDLE: if m_IE_i & |eligible, go to IRQ_PENDING and latch the selected index into irq_id_q; otherwise stay in IDLE and hold irq_id_q.
REQ-019 IRQ_PENDING: ctrl_ack_i -> IRQ_DONE; else ctrl_kill_i -> IDLE; else stay in IRQ_PENDING.
REQ-020 ctrl_ack_i and ctrl_kill_i high together in IRQ_PENDING: ack wins.
REQ-021 On ack, the edge pending bit for irq_id_q shall clear on the same clock edge; level sources are unaffected.
REQ-022 Kill shall leave all pending bits unchanged, so the source is re-arbitrated from IDLE.
REQ-023 IRQ_DONE shall return to IDLE unconditionally after one cycle; no new request is captured in IRQ_DONE.
REQ-024 irq_id_ctrl_o shall be stable throughout IRQ_PENDING and IRQ_DONE; priority changes and deassertion of m_IE_i or irq_en_i do not alter or withdraw a request already in IRQ_PENDING.
REQ-025 Set and clear of the same edge pending bit in the same cycle: set wins (the new edge is not lost).
REQ-026 Latency, level source: irq_i high in cycle N with enables set in IDLE -> irq_req_ctrl_o high in cycle N+1.
REQ-027 Latency, edge source: rising edge in cycle N -> pending in N+1 -> irq_req_ctrl_o high in N+2.
REQ-028 ctrl_ack_i and ctrl_kill_i shall be ignored in IDLE and IRQ_DONE.
REQ-029 Edge pending bits shall set regardless of m_IE_i and irq_en_i (masking affects selection only).

Reset
REQ-030 On rst_n low, asynchronously: state = IDLE, irq_id_q = 0, irq_q = 0, all edge pending bits = 0.
REQ-031 Reset outputs: irq_req_ctrl_o = 0, irq_id_ctrl_o = 0; irq_pending_o shows only the live level-source bits.
REQ-032 Reset asserted mid-handshake (IRQ_PENDING or IRQ_DONE) shall abort immediately, with no ack side-effects.
REQ-033 irq_q resets to 0, so an edge line already high at reset release is detected as a rising edge.

Verification
REQ-034 NUM_IRQ=32, level: m_IE_i=1, irq_en_i=all ones, irq_i=0x0000_0050 at cycle N -> irq_req_ctrl_o=1 at N+1 with irq_id_ctrl_o=4; ack -> IRQ_DONE for 1 cycle -> IDLE -> re-request ID 4 (line still high).
REQ-035 Edge source 7 (EDGE_MASK bit 7 = 1): pulse irq_i[7] for 1 cycle -> irq_pending_o[7]=1 -> request ID 7 at N+2; ack -> pending[7]=0, no re-request.
REQ-036 Kill: request ID 3 pending, ctrl_kill_i=1 -> IDLE next cycle, pending[3] still 1, request ID 3 again one cycle later.
REQ-037 Simultaneous ack+kill -> IRQ_DONE (ack wins); new edge on the acked source in the same cycle -> pending bit remains 1.
REQ-038 Masking: irq_en_i[2]=0 with source 2 pending -> no request; m_IE_i=0 with any eligible source -> no request; enable in IRQ_PENDING dropped -> request and ID held.
REQ-039 Reset asserted in IRQ_PENDING -> irq_req_ctrl_o=0 and irq_id_ctrl_o=0 asynchronously; repeat REQ-034 with NUM_IRQ=1 and NUM_IRQ=5.

Source files
------------

// File: rtl/zeroriscy_irq_ctrl_multi.sv
// Multi-source interrupt controller: per-source edge/level capture, fixed-priority
// selection and a request/ack/kill handshake with the core controller.
module zeroriscy_irq_ctrl_multi #(
    parameter int unsigned        NUM_IRQ   = 32,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    input  logic               m_IE_i,
    input  logic               ctrl_ack_i,
    input  logic               ctrl_kill_i,
    output logic               irq_req_ctrl_o,
    output logic [4:0]         irq_id_ctrl_o,
    output logic [NUM_IRQ-1:0] irq_pending_o
);

    typedef enum logic [1:0] {
        IDLE,
        IRQ_PENDING,
        IRQ_DONE
    } state_t;

    state_t             r_state;
    logic [4:0]         r_irqId;
    logic               r_irqReq;
    logic [NUM_IRQ-1:0] r_irqQ;
    logic [NUM_IRQ-1:0] r_edgePending;

    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_pending;
    logic [NUM_IRQ-1:0] w_eligible;
    logic [NUM_IRQ-1:0] w_ackClear;
    logic [4:0]         w_selId;
    logic               w_anyEligible;
    logic               w_ackFire;

    assign w_rise        = irq_i & ~r_irqQ & EDGE_MASK;
    assign w_pending     = (r_edgePending & EDGE_MASK) | (irq_i & ~EDGE_MASK);
    assign w_eligible    = w_pending & irq_en_i;
    assign w_anyEligible = |w_eligible;
    assign w_ackFire     = (r_state == IRQ_PENDING) && ctrl_ack_i;

    // Scan from the top down so the lowest eligible index wins.
    always_comb begin
        w_selId = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_selId = 5'(i);
            end
        end
    end

    always_comb begin
        w_ackClear = '0;
        if (w_ackFire) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (r_irqId == 5'(i)) begin
                    w_ackClear[i] = 1'b1;
                end
            end
        end
    end

    // A fresh rising edge overrides an ack clear of the same bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irqQ        <= '0;
            r_edgePending <= '0;
        end else begin
            r_irqQ        <= irq_i;
            r_edgePending <= ((r_edgePending & ~w_ackClear) | w_rise) & EDGE_MASK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_irqId  <= '0;
            r_irqReq <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m_IE_i && w_anyEligible) begin
                        r_state  <= IRQ_PENDING;
                        r_irqId  <= w_selId;
                        r_irqReq <= 1'b1;
                    end
                end
                IRQ_PENDING: begin
                    if (ctrl_ack_i) begin
                        r_state  <= IRQ_DONE;
                        r_irqReq <= 1'b0;
                    end else if (ctrl_kill_i) begin
                        r_state  <= IDLE;
                        r_irqReq <= 1'b0;
                    end
                end
                IRQ_DONE: begin
                    r_state  <= IDLE;
                    r_irqReq <= 1'b0;
                end
                default: begin
                    r_state  <= IDLE;
                    r_irqReq <= 1'b0;
                end
            endcase
        end
    end

    assign irq_req_ctrl_o = r_irqReq;
    assign irq_id_ctrl_o  = r_irqId;
    assign irq_pending_o  = w_pending;

endmodule

// File: tb/tb_zeroriscy_irq_ctrl_multi.sv
// Directed-vector bench for zeroriscy_irq_ctrl_multi: 32-source main instance with
// edge sources 3 and 7, plus 1- and 5-source level instances.
module tb_zeroriscy_irq_ctrl_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] irq;
    logic [31:0] irqEn;
    logic        mIE;
    logic        ack;
    logic        kill;
    logic        req;
    logic [4:0]  id;
    logic [31:0] pending;

    logic [0:0]  irq1;
    logic [0:0]  irqEn1;
    logic        req1;
    logic [4:0]  id1;
    logic [0:0]  pending1;
    logic [4:0]  irq5;
    logic [4:0]  irqEn5;
    logic        req5;
    logic [4:0]  id5;
    logic [4:0]  pending5;
    logic        smallMIE;
    logic        smallAck;
    logic        smallKill;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic [31:0] irq;
        logic [31:0] en;
        logic        mie;
        logic        ack;
        logic        kill;
        logic        expReq;
        logic [4:0]  expId;
        logic [31:0] expPend;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    zeroriscy_irq_ctrl_multi #(.NUM_IRQ(32), .EDGE_MASK(32'h0000_0088)) dut (
        .clk(clk), .rst_n(rst_n), .irq_i(irq), .irq_en_i(irqEn), .m_IE_i(mIE),
        .ctrl_ack_i(ack), .ctrl_kill_i(kill), .irq_req_ctrl_o(req),
        .irq_id_ctrl_o(id), .irq_pending_o(pending)
    );

    zeroriscy_irq_ctrl_multi #(.NUM_IRQ(1), .EDGE_MASK(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .irq_i(irq1), .irq_en_i(irqEn1), .m_IE_i(smallMIE),
        .ctrl_ack_i(smallAck), .ctrl_kill_i(smallKill), .irq_req_ctrl_o(req1),
        .irq_id_ctrl_o(id1), .irq_pending_o(pending1)
    );

    zeroriscy_irq_ctrl_multi #(.NUM_IRQ(5), .EDGE_MASK(5'b0)) dut5 (
        .clk(clk), .rst_n(rst_n), .irq_i(irq5), .irq_en_i(irqEn5), .m_IE_i(smallMIE),
        .ctrl_ack_i(smallAck), .ctrl_kill_i(smallKill), .irq_req_ctrl_o(req5),
        .irq_id_ctrl_o(id5), .irq_pending_o(pending5)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            passCount++;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        irq   = v.irq;
        irqEn = v.en;
        mIE   = v.mie;
        ack   = v.ack;
        kill  = v.kill;
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic [31:0] i, input logic [31:0] e, input logic m,
                          input logic a, input logic k, input logic r,
                          input logic [4:0] d, input logic [31:0] p);
        vec_t v;
        v.irq = i; v.en = e; v.mie = m; v.ack = a; v.kill = k;
        v.expReq = r; v.expId = d; v.expPend = p;
        vecs.push_back(v);
    endtask

    localparam logic [31:0] ALL = 32'hFFFF_FFFF;

    initial begin
        // Inputs / expected state after the following rising edge.
        addVec(32'h50, ALL, 1, 0, 0, 1, 4,  32'h50);        // level 4 selected
        addVec(32'h50, ALL, 1, 1, 0, 0, 4,  32'h50);        // ack -> DONE
        addVec(32'h50, ALL, 1, 0, 0, 0, 4,  32'h50);        // DONE -> IDLE
        addVec(32'h50, ALL, 1, 0, 0, 1, 4,  32'h50);        // re-request
        addVec(32'h00, ALL, 1, 0, 1, 0, 4,  32'h00);        // kill
        addVec(32'h80, ALL, 1, 0, 0, 0, 4,  32'h80);        // edge 7 rises
        addVec(32'h00, ALL, 1, 0, 0, 1, 7,  32'h80);        // request at N+2
        addVec(32'h00, ALL, 1, 1, 0, 0, 7,  32'h00);        // ack clears edge
        addVec(32'h00, ALL, 1, 0, 0, 0, 7,  32'h00);
        addVec(32'h00, ALL, 1, 0, 0, 0, 7,  32'h00);        // no re-request
        addVec(32'h08, ALL, 1, 0, 0, 0, 7,  32'h08);        // edge 3 rises
        addVec(32'h08, ALL, 1, 0, 0, 1, 3,  32'h08);
        addVec(32'h00, ALL, 1, 0, 1, 0, 3,  32'h08);        // kill keeps pending
        addVec(32'h00, ALL, 1, 0, 0, 1, 3,  32'h08);        // re-arbitrated
        addVec(32'h08, ALL, 1, 1, 1, 0, 3,  32'h08);        // ack+kill, new edge wins
        addVec(32'h08, ALL, 1, 0, 0, 0, 3,  32'h08);        // DONE -> IDLE
        addVec(32'h08, ALL, 1, 0, 0, 1, 3,  32'h08);
        addVec(32'h00, ALL, 1, 1, 0, 0, 3,  32'h00);
        addVec(32'h00, ALL, 1, 1, 0, 0, 3,  32'h00);        // ack in DONE ignored
        addVec(32'h00, ALL, 1, 1, 1, 0, 3,  32'h00);        // ack/kill in IDLE ignored
        addVec(32'h04, 32'hFFFF_FFFB, 1, 0, 0, 0, 3, 32'h04); // source 2 masked
        addVec(32'h04, ALL, 0, 0, 0, 0, 3,  32'h04);        // global disable
        addVec(32'h04, ALL, 1, 0, 0, 1, 2,  32'h04);
        addVec(32'h01, 32'h0, 0, 0, 0, 1, 2, 32'h01);       // request held
        addVec(32'h01, 32'h0, 0, 0, 1, 0, 2, 32'h01);
        addVec(32'h05, ALL, 1, 0, 0, 1, 0,  32'h05);        // lowest index wins
        addVec(32'h05, ALL, 1, 1, 0, 0, 0,  32'h05);
        addVec(32'h00, ALL, 1, 0, 0, 0, 0,  32'h00);
        addVec(32'h8000_0000, ALL, 1, 0, 0, 1, 31, 32'h8000_0000);
        addVec(32'h00, ALL, 1, 0, 1, 0, 31, 32'h00);
        addVec(32'h80, 32'h0, 0, 0, 0, 0, 31, 32'h80);      // edge sets while masked
        addVec(32'h00, 32'h0, 0, 0, 0, 0, 31, 32'h80);
        addVec(32'h00, ALL, 1, 0, 0, 1, 7,  32'h80);
        addVec(32'h00, ALL, 1, 1, 0, 0, 7,  32'h00);
        addVec(32'h00, ALL, 1, 0, 0, 0, 7,  32'h00);

        rst_n = 1'b0;
        irq = 32'h58; irqEn = '0; mIE = 0; ack = 0; kill = 0;
        irq1 = '0; irqEn1 = '0; irq5 = '0; irqEn5 = '0;
        smallMIE = 0; smallAck = 0; smallKill = 0;
        #2;
        checkOutput("reset_req", 32'(req), 32'h0);
        checkOutput("reset_id", 32'(id), 32'h0);
        checkOutput("reset_pending", pending, 32'h50);
        checkOutput("reset_req5", 32'(req5), 32'h0);
        @(posedge clk);
        #1;
        irq   = '0;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_req", i), 32'(req), 32'(vecs[i].expReq));
            checkOutput($sformatf("v%0d_id", i), 32'(id), 32'(vecs[i].expId));
            checkOutput($sformatf("v%0d_pending", i), pending, vecs[i].expPend);
        end

        // Reset dropped while a request is outstanding.
        irq = 32'hD0; irqEn = ALL; mIE = 1; ack = 0; kill = 0;
        @(posedge clk);
        #1;
        checkOutput("prerst_req", 32'(req), 32'h1);
        checkOutput("prerst_id", 32'(id), 32'h4);
        checkOutput("prerst_pending", pending, 32'hD0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_req", 32'(req), 32'h0);
        checkOutput("midrst_id", 32'(id), 32'h0);
        checkOutput("midrst_pending", pending, 32'h50);
        irq = 32'h80;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postrst_pending", pending, 32'h80);
        checkOutput("postrst_req", 32'(req), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("postrst_req2", 32'(req), 32'h1);
        checkOutput("postrst_id2", 32'(id), 32'h7);
        irq = '0; mIE = 0;

        // Narrow instances repeat the basic level handshake.
        irq1 = 1'b1; irqEn1 = 1'b1; irq5 = 5'h10; irqEn5 = 5'h1F; smallMIE = 1;
        @(posedge clk);
        #1;
        checkOutput("n1_req", 32'(req1), 32'h1);
        checkOutput("n1_id", 32'(id1), 32'h0);
        checkOutput("n1_pending", 32'(pending1), 32'h1);
        checkOutput("n5_req", 32'(req5), 32'h1);
        checkOutput("n5_id", 32'(id5), 32'h4);
        checkOutput("n5_pending", 32'(pending5), 32'h10);
        smallAck = 1;
        @(posedge clk);
        #1;
        checkOutput("n1_ack_req", 32'(req1), 32'h0);
        checkOutput("n5_ack_req", 32'(req5), 32'h0);
        smallAck = 0;
        @(posedge clk);
        #1;
        checkOutput("n1_done_req", 32'(req1), 32'h0);
        checkOutput("n5_done_req", 32'(req5), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("n1_rereq", 32'(req1), 32'h1);
        checkOutput("n1_reid", 32'(id1), 32'h0);
        checkOutput("n5_rereq", 32'(req5), 32'h1);
        checkOutput("n5_reid", 32'(id5), 32'h4);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
